// File: rtl/trace_reader_pkg.sv
// Shared definitions for the trace reader: FSM state encoding and the
// width helpers used to size the index, sum and active-count fields.
// All widths derive from channel count and per-channel trace width.
package trace_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LP_BASE_WIDTH_DEF = 6;
  localparam int LP_CHANNELS_DEF   = 4;

  // Channel index width; channel counts start at 2 so this is never zero.
  function automatic int f_idx_w(input int channels);
    return $clog2(channels);
  endfunction

  // N*(2^W-1) < 2^(W+clog2 N), so this width cannot overflow.
  function automatic int f_sum_w(input int base_width, input int channels);
    return base_width + $clog2(channels);
  endfunction

  // Count of nonzero channels runs 0..N, hence one bit above the index.
  function automatic int f_cnt_w(input int channels);
    return $clog2(channels) + 1;
  endfunction

endpackage

// File: rtl/trace_reader.sv
// Snapshots all trace channels on request, then scans them one per cycle
// for sum, max (lowest index wins ties) and nonzero count.
// Latency: o_valid p_channels+1 cycles after accept; requests while busy are dropped.
module trace_reader
  import trace_reader_pkg::*;
#(
  parameter int p_base_width = LP_BASE_WIDTH_DEF,
  parameter int p_channels   = LP_CHANNELS_DEF
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  logic [p_channels*p_base_width-1:0]            i_ln,
  input  logic [p_channels-1:0]                         i_clr,
  input  logic                                          i_sample,
  output logic                                          o_busy,
  output logic                                          o_valid,
  output logic                                          o_drop,
  output logic [f_sum_w(p_base_width, p_channels)-1:0]  o_sum,
  output logic [f_idx_w(p_channels)-1:0]                o_max_idx,
  output logic [p_base_width-1:0]                       o_max_val,
  output logic [f_cnt_w(p_channels)-1:0]                o_active_cnt,
  output logic [p_channels-1:0]                         o_fresh
);

  localparam int LP_IW = f_idx_w(p_channels);
  localparam int LP_SW = f_sum_w(p_base_width, p_channels);
  localparam int LP_CW = f_cnt_w(p_channels);
  localparam logic [LP_IW-1:0] LP_LAST_IDX = LP_IW'(p_channels - 1);

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic                      w_accept;
  logic                      w_scan_en;
  logic                      w_done;
  logic                      w_last;

  logic [p_base_width-1:0]   r_snap [p_channels];
  logic [p_channels-1:0]     r_snap_clr;
  logic [LP_IW-1:0]          r_idx;
  logic [LP_SW-1:0]          r_acc_sum;
  logic [p_base_width-1:0]   r_acc_max_val;
  logic [LP_IW-1:0]          r_acc_max_idx;
  logic [LP_CW-1:0]          r_acc_cnt;
  logic [p_base_width-1:0]   w_ch;

  logic                      r_valid;
  logic                      r_drop;
  logic [LP_SW-1:0]          r_sum;
  logic [LP_IW-1:0]          r_max_idx;
  logic [p_base_width-1:0]   r_max_val;
  logic [LP_CW-1:0]          r_active_cnt;
  logic [p_channels-1:0]     r_fresh;

  assign w_last = (r_idx == LP_LAST_IDX);
  assign w_ch   = r_snap[r_idx];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: accept from IDLE, scan all channels, one DONE cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_sample) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE:               w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: busy covers SCAN and DONE, so a DONE-cycle request is dropped
  always_comb begin
    w_accept  = 1'b0;
    w_scan_en = 1'b0;
    w_done    = 1'b0;
    o_busy    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_busy   = 1'b0;
        w_accept = i_sample;
      end
      ST_SCAN: w_scan_en = 1'b1;
      ST_DONE: w_done    = 1'b1;
      default: ;
    endcase
  end

  // Snapshot traces and event flags on accept; later input changes are ignored
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < p_channels; k++) r_snap[k] <= '0;
      r_snap_clr <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < p_channels; k++) r_snap[k] <= i_ln[k*p_base_width +: p_base_width];
      r_snap_clr <= i_clr;
    end
  end

  // Sequential scan: one channel per cycle; strict > keeps the lowest index on ties
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx         <= '0;
      r_acc_sum     <= '0;
      r_acc_max_val <= '0;
      r_acc_max_idx <= '0;
      r_acc_cnt     <= '0;
    end else if (w_accept) begin
      r_idx         <= '0;
      r_acc_sum     <= '0;
      r_acc_max_val <= '0;
      r_acc_max_idx <= '0;
      r_acc_cnt     <= '0;
    end else if (w_scan_en) begin
      r_acc_sum <= r_acc_sum + LP_SW'(w_ch);
      r_acc_cnt <= r_acc_cnt + LP_CW'(w_ch != '0);
      if (w_ch > r_acc_max_val) begin
        r_acc_max_val <= w_ch;
        r_acc_max_idx <= r_idx;
      end
      r_idx <= r_idx + LP_IW'(1);
    end
  end

  // Result registers: loaded only in DONE so they hold until the next scan ends
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid      <= 1'b0;
      r_drop       <= 1'b0;
      r_sum        <= '0;
      r_max_idx    <= '0;
      r_max_val    <= '0;
      r_active_cnt <= '0;
      r_fresh      <= '0;
    end else begin
      r_valid <= w_done;
      r_drop  <= i_sample & o_busy;
      if (w_done) begin
        r_sum        <= r_acc_sum;
        r_max_idx    <= r_acc_max_idx;
        r_max_val    <= r_acc_max_val;
        r_active_cnt <= r_acc_cnt;
        r_fresh      <= r_snap_clr;
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_drop       = r_drop;
  assign o_sum        = r_sum;
  assign o_max_idx    = r_max_idx;
  assign o_max_val    = r_max_val;
  assign o_active_cnt = r_active_cnt;
  assign o_fresh      = r_fresh;

endmodule

// File: tb/tb_trace_reader.sv
// Directed bench for trace_reader with 4 channels of 6-bit traces.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_trace_reader;

  logic        i_clk;
  logic        i_rst_n;
  logic [23:0] i_ln;
  logic [3:0]  i_clr;
  logic        i_sample;
  logic        o_busy;
  logic        o_valid;
  logic        o_drop;
  logic [7:0]  o_sum;
  logic [1:0]  o_max_idx;
  logic [5:0]  o_max_val;
  logic [2:0]  o_active_cnt;
  logic [3:0]  o_fresh;

  int n_vec;
  int n_err;

  trace_reader #(.p_base_width(6), .p_channels(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ln         (i_ln),
    .i_clr        (i_clr),
    .i_sample     (i_sample),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_drop       (o_drop),
    .o_sum        (o_sum),
    .o_max_idx    (o_max_idx),
    .o_max_val    (o_max_val),
    .o_active_cnt (o_active_cnt),
    .o_fresh      (o_fresh)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Present a one-cycle request; returns at the falling edge after the accept edge.
  task automatic start_sample(input logic [23:0] ln, input logic [3:0] clr);
    @(negedge i_clk);
    i_ln     = ln;
    i_clr    = clr;
    i_sample = 1'b1;
    @(negedge i_clk);
    i_sample = 1'b0;
  endtask

  // Falling edges until o_valid is seen; -1 if it never comes.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (o_valid === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_ln = '0; i_clr = '0; i_sample = 1'b0;
    repeat (2) @(negedge i_clk);
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_vec++; if (o_valid !== 1'b0 || o_drop !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got valid=%b drop=%b expected 0/0", o_valid, o_drop); end
    n_vec++; if (o_sum !== 8'd0 || o_max_idx !== 2'd0 || o_max_val !== 6'd0 || o_active_cnt !== 3'd0 || o_fresh !== 4'd0) begin
      n_err++; $display("FAIL reset_results: got sum=%0d idx=%0d val=%0d cnt=%0d fresh=%b expected all 0", o_sum, o_max_idx, o_max_val, o_active_cnt, o_fresh);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_basic;
    int lat;
    start_sample({6'd5, 6'd0, 6'd20, 6'd63}, 4'b0101);
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", o_busy); end
    wait_valid(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_vec++; if (o_sum !== 8'd88) begin n_err++; $display("FAIL basic_sum: got %0d expected 88", o_sum); end
    n_vec++; if (o_max_idx !== 2'd0) begin n_err++; $display("FAIL basic_idx: got %0d expected 0", o_max_idx); end
    n_vec++; if (o_max_val !== 6'd63) begin n_err++; $display("FAIL basic_val: got %0d expected 63", o_max_val); end
    n_vec++; if (o_active_cnt !== 3'd3) begin n_err++; $display("FAIL basic_cnt: got %0d expected 3", o_active_cnt); end
    n_vec++; if (o_fresh !== 4'b0101) begin n_err++; $display("FAIL basic_fresh: got %b expected 0101", o_fresh); end
    @(negedge i_clk);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_width: got %b expected 0", o_valid); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got busy=%b expected 0", o_busy); end
    i_ln = 24'hFFFFFF;
    repeat (3) @(negedge i_clk);
    n_vec++; if (o_sum !== 8'd88 || o_max_val !== 6'd63) begin n_err++; $display("FAIL basic_hold: got sum=%0d val=%0d expected 88/63", o_sum, o_max_val); end
  endtask

  task automatic test_tie;
    int lat;
    start_sample({6'd1, 6'd40, 6'd40, 6'd10}, 4'b0000);
    wait_valid(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL tie_latency: got %0d expected 5", lat); end
    n_vec++; if (o_max_idx !== 2'd1) begin n_err++; $display("FAIL tie_idx: got %0d expected 1", o_max_idx); end
    n_vec++; if (o_max_val !== 6'd40) begin n_err++; $display("FAIL tie_val: got %0d expected 40", o_max_val); end
    n_vec++; if (o_sum !== 8'd91) begin n_err++; $display("FAIL tie_sum: got %0d expected 91", o_sum); end
    n_vec++; if (o_active_cnt !== 3'd4) begin n_err++; $display("FAIL tie_cnt: got %0d expected 4", o_active_cnt); end
  endtask

  task automatic test_zero;
    int lat;
    start_sample(24'd0, 4'b0000);
    wait_valid(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL zero_latency: got %0d expected 5", lat); end
    n_vec++; if (o_sum !== 8'd0 || o_max_idx !== 2'd0 || o_max_val !== 6'd0 || o_active_cnt !== 3'd0) begin
      n_err++; $display("FAIL zero_results: got sum=%0d idx=%0d val=%0d cnt=%0d expected all 0", o_sum, o_max_idx, o_max_val, o_active_cnt);
    end
  endtask

  task automatic test_drop_busy;
    int lat;
    int extra;
    start_sample({6'd7, 6'd9, 6'd30, 6'd2}, 4'b0011);
    @(negedge i_clk);
    i_sample = 1'b1;
    i_ln     = {6'd63, 6'd63, 6'd63, 6'd63};
    @(negedge i_clk);
    i_sample = 1'b0;
    n_vec++; if (o_drop !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b expected 1", o_drop); end
    @(negedge i_clk);
    n_vec++; if (o_drop !== 1'b0) begin n_err++; $display("FAIL drop_width: got %b expected 0", o_drop); end
    wait_valid(lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL drop_latency: got %0d expected 2", lat); end
    n_vec++; if (o_sum !== 8'd48 || o_max_idx !== 2'd1 || o_max_val !== 6'd30 || o_fresh !== 4'b0011) begin
      n_err++; $display("FAIL drop_results: got sum=%0d idx=%0d val=%0d fresh=%b expected 48/1/30/0011", o_sum, o_max_idx, o_max_val, o_fresh);
    end
    extra = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) extra++;
    end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL drop_no_requeue: got %0d extra valids expected 0", extra); end
  endtask

  task automatic test_drop_done;
    int extra;
    start_sample({6'd0, 6'd0, 6'd0, 6'd3}, 4'b0000);
    repeat (4) @(negedge i_clk);
    i_sample = 1'b1;
    @(negedge i_clk);
    i_sample = 1'b0;
    n_vec++; if (o_valid !== 1'b1 || o_drop !== 1'b1) begin n_err++; $display("FAIL done_drop: got valid=%b drop=%b expected 1/1", o_valid, o_drop); end
    n_vec++; if (o_sum !== 8'd3 || o_active_cnt !== 3'd1) begin n_err++; $display("FAIL done_results: got sum=%0d cnt=%0d expected 3/1", o_sum, o_active_cnt); end
    extra = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_valid === 1'b1 || o_busy === 1'b1) extra++;
    end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL done_no_start: got %0d busy/valid cycles expected 0", extra); end
  endtask

  task automatic test_freeze;
    int lat;
    start_sample({6'd60, 6'd5, 6'd5, 6'd5}, 4'b1000);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (o_valid === 1'b1) begin
        lat = c;
        break;
      end
      i_ln  = 24'($urandom);
      i_clr = 4'($urandom);
      @(negedge i_clk);
    end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL freeze_latency: got %0d expected 5", lat); end
    n_vec++; if (o_sum !== 8'd75) begin n_err++; $display("FAIL freeze_sum: got %0d expected 75", o_sum); end
    n_vec++; if (o_max_idx !== 2'd3 || o_max_val !== 6'd60) begin n_err++; $display("FAIL freeze_max: got idx=%0d val=%0d expected 3/60", o_max_idx, o_max_val); end
    n_vec++; if (o_active_cnt !== 3'd4) begin n_err++; $display("FAIL freeze_cnt: got %0d expected 4", o_active_cnt); end
    n_vec++; if (o_fresh !== 4'b1000) begin n_err++; $display("FAIL freeze_fresh: got %b expected 1000", o_fresh); end
    i_ln  = '0;
    i_clr = '0;
  endtask

  task automatic test_reset_mid;
    int lat;
    int extra;
    start_sample({6'd50, 6'd40, 6'd30, 6'd20}, 4'b1111);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    n_vec++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl: got busy=%b valid=%b expected 0/0", o_busy, o_valid); end
    n_vec++; if (o_sum !== 8'd0 || o_max_val !== 6'd0 || o_fresh !== 4'd0 || o_active_cnt !== 3'd0) begin
      n_err++; $display("FAIL rstmid_results: got sum=%0d val=%0d fresh=%b cnt=%0d expected all 0", o_sum, o_max_val, o_fresh, o_active_cnt);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) extra++;
    end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL rstmid_no_valid: got %0d valids expected 0", extra); end
    start_sample({6'd4, 6'd3, 6'd2, 6'd1}, 4'b0000);
    wait_valid(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL rstmid_latency: got %0d expected 5", lat); end
    n_vec++; if (o_sum !== 8'd10 || o_max_idx !== 2'd3 || o_max_val !== 6'd4 || o_active_cnt !== 3'd4) begin
      n_err++; $display("FAIL rstmid_rescan: got sum=%0d idx=%0d val=%0d cnt=%0d expected 10/3/4/4", o_sum, o_max_idx, o_max_val, o_active_cnt);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_tie();
    test_zero();
    test_drop_busy();
    test_drop_done();
    test_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
